// File: rtl/timer_sched_ctrl.sv
// timer_sched_ctrl: prescaled up/down period timer with one-shot/periodic modes and a sticky irq
module timer_sched_ctrl #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic                 dir,
  input  logic [PSC_WIDTH-1:0] psc,
  input  logic [WIDTH-1:0]     period,
  input  logic                 irq_clr,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 tick,
  output logic                 irq
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic sh_mode, sh_dir;
  logic [PSC_WIDTH-1:0] sh_psc, psc_cnt;
  logic [WIDTH-1:0] sh_period;
  logic load, run, en, evt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // stop beats start; a restart or stop suppresses counting on its edge
  always_comb begin
    run = state == RUN;
    load = start && !stop;
    en = run && !stop && !start && psc_cnt == sh_psc;
    evt = en && (sh_dir ? count == sh_period : count == '0);
    state_nx = stop ? IDLE : start ? RUN : (evt && !sh_mode) ? IDLE : state;
  end
  assign busy = state == RUN;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      psc_cnt <= '0;
      sh_mode <= 1'b0;
      sh_dir <= 1'b0;
      sh_psc <= '0;
      sh_period <= '0;
      tick <= 1'b0;
      irq <= 1'b0;
    end else begin
      tick <= evt;
      irq <= evt || (irq && !irq_clr);
      if (load) begin
        sh_mode <= mode;
        sh_dir <= dir;
        sh_psc <= psc;
        sh_period <= period;
        psc_cnt <= '0;
        count <= dir ? '0 : period;
      end else if (run && !stop) begin
        psc_cnt <= en ? '0 : psc_cnt + 1'b1;
        if (en)
          count <= evt ? (sh_dir ? '0 : sh_period) : (sh_dir ? count + 1'b1 : count - 1'b1);
      end
    end
endmodule

// File: tb/tb_timer_sched_ctrl.sv
// tb_timer_sched_ctrl: directed scenario tests for timer_sched_ctrl
module tb_timer_sched_ctrl;
  logic clk = 1'b0;
  logic rst, start, stop, mode, dir, irq_clr;
  logic [7:0] psc;
  logic [15:0] period;
  logic [15:0] count;
  logic busy, tick, irq;
  int passed = 0;
  int total = 0;

  timer_sched_ctrl #(.WIDTH(16), .PSC_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .psc(psc), .period(period), .irq_clr(irq_clr),
    .count(count), .busy(busy), .tick(tick), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic m, input logic d, input logic [7:0] p, input logic [15:0] per);
    mode = m; dir = d; psc = p; period = per; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; stop = 0; mode = 0; dir = 0; irq_clr = 0; psc = 0; period = 0;
    #1;
    total++; if (count !== 16'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
    #11 rst = 1'b1;
    step();
  endtask

  task automatic test_periodic_down();
    logic [15:0] e;
    do_start(1'b1, 1'b0, 8'd3, 16'd4);
    for (int n = 0; n <= 40; n++) begin
      e = 16'(4 - ((n % 20) / 4));
      total++; if (count !== e) $display("FAIL per_count n=%0d got %0d want %0d", n, count, e); else passed++;
      total++; if (tick !== (n > 0 && n % 20 == 0)) $display("FAIL per_tick n=%0d got %b", n, tick); else passed++;
      total++; if (irq !== (n >= 20)) $display("FAIL per_irq n=%0d got %b", n, irq); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL per_busy n=%0d got %b want 1", n, busy); else passed++;
      step();
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    total++; if (irq !== 1'b0) $display("FAIL per_irq_clr got %b want 0", irq); else passed++;
  endtask

  task automatic test_one_shot_up();
    do_start(1'b0, 1'b1, 8'd0, 16'd2);
    for (int n = 0; n <= 8; n++) begin
      total++; if (count !== ((n == 1 || n == 2) ? 16'(n) : 16'd0)) $display("FAIL os_count n=%0d got %0d", n, count); else passed++;
      total++; if (tick !== (n == 3)) $display("FAIL os_tick n=%0d got %b", n, tick); else passed++;
      total++; if (busy !== (n < 3)) $display("FAIL os_busy n=%0d got %b", n, busy); else passed++;
      total++; if (irq !== (n >= 3)) $display("FAIL os_irq n=%0d got %b", n, irq); else passed++;
      step();
    end
  endtask

  task automatic test_shadow_restart();
    do_start(1'b1, 1'b0, 8'd3, 16'd4);
    psc = 8'd0; period = 16'd1; dir = 1'b1; mode = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      total++; if (count !== 16'(4 - n / 4)) $display("FAIL shd_count n=%0d got %0d want %0d", n, count, 4 - n / 4); else passed++;
    end
    do_start(1'b1, 1'b0, 8'd3, 16'd4);
    total++; if (count !== 16'd4) $display("FAIL rst_reload got %0d want 4", count); else passed++;
    for (int m = 1; m <= 20; m++) begin
      step();
      total++; if (tick !== (m == 20)) $display("FAIL rst_tick m=%0d got %b", m, tick); else passed++;
    end
    total++; if (count !== 16'd4) $display("FAIL rst_evt_count got %0d want 4", count); else passed++;
  endtask

  task automatic test_irq_set_wins();
    irq_clr = 1'b1;
    do_start(1'b1, 1'b0, 8'd3, 16'd4);
    irq_clr = 1'b0;
    total++; if (irq !== 1'b0) $display("FAIL sw_pre got %b want 0", irq); else passed++;
    for (int n = 1; n <= 19; n++) step();
    total++; if (tick !== 1'b0) $display("FAIL sw_tick19 got %b want 0", tick); else passed++;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    total++; if (tick !== 1'b1) $display("FAIL sw_tick20 got %b want 1", tick); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL sw_set_wins got %b want 1", irq); else passed++;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    total++; if (irq !== 1'b0) $display("FAIL sw_clear got %b want 0", irq); else passed++;
  endtask

  task automatic test_back_to_back();
    do_start(1'b1, 1'b0, 8'd0, 16'd9);
    step(); step(); step();
    total++; if (count !== 16'd6) $display("FAIL bb_pre got %0d want 6", count); else passed++;
    period = 16'd2; stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL bb_busy got %b want 0", busy); else passed++;
    total++; if (count !== 16'd6) $display("FAIL bb_frozen got %0d want 6", count); else passed++;
    step(); step(); step();
    total++; if (count !== 16'd6 || tick !== 1'b0 || busy !== 1'b0)
      $display("FAIL bb_idle got count=%0d tick=%b busy=%b want 6/0/0", count, tick, busy); else passed++;
    do_start(1'b1, 1'b0, 8'd1, 16'd0);
    for (int n = 0; n <= 8; n++) begin
      total++; if (tick !== (n > 0 && n % 2 == 0)) $display("FAIL p0_tick n=%0d got %b", n, tick); else passed++;
      total++; if (count !== 16'd0) $display("FAIL p0_count n=%0d got %0d want 0", n, count); else passed++;
      if (n < 8) step();
    end
    rst = 1'b0;
    #1;
    total++; if (tick !== 1'b0 || busy !== 1'b0 || irq !== 1'b0 || count !== 16'd0)
      $display("FAIL async_rst got tick=%b busy=%b irq=%b count=%0d want 0/0/0/0", tick, busy, irq, count); else passed++;
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_periodic_down();
    test_one_shot_up();
    test_shadow_restart();
    test_irq_set_wins();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
